// File: rtl/flash_apb_master.sv
// flash_apb_master: single-outstanding APB master bridging a valid/ready host port to a flash responder.
// Optional ACCESS-phase timeout abort enabled by defining FLASH_APB_TIMEOUT_EN.
`default_nettype none

module flash_apb_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        apb_sel,
    output logic        apb_enable,
    output logic        apb_write,
    output logic [7:0]  apb_addr,
    output logic [31:0] apb_wdata,
    input  logic [31:0] apb_rdata,
    input  logic        apb_ready,
    input  logic        apb_slverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e      state_q;
    logic        sel_q;
    logic        enable_q;
    logic        write_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        accept;
    logic        timeout;

    // Gated by reset so the host never sees ready while reset is held.
    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

`ifdef FLASH_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Abort fires at the end of the TIMEOUT_CYCLES-th ACCESS cycle without apb_ready.
    assign timeout = (state_q == S_ACCESS) && !apb_ready &&
                     (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (accept) begin
            wait_cnt_q <= '0;
        end else if ((state_q == S_ACCESS) && !apb_ready) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_write ? req_wdata : 32'd0;
                        sel_q   <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    enable_q <= 1'b1;
                    state_q  <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb_ready) begin
                        sel_q       <= 1'b0;
                        enable_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= apb_slverr;
                        rsp_rdata_q <= (!write_q && !apb_slverr) ? apb_rdata : 32'd0;
                        state_q     <= S_RESP;
                    end else if (timeout) begin
                        sel_q       <= 1'b0;
                        enable_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign apb_sel    = sel_q;
    assign apb_enable = enable_q;
    assign apb_write  = write_q;
    assign apb_addr   = addr_q;
    assign apb_wdata  = wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_apb_master.sv
// tb_flash_apb_master: directed self-checking bench for flash_apb_master.
// Covers reset, write, waited read, slave error, mid-ACCESS reset and the ACCESS timeout (FLASH_APB_TIMEOUT_EN).
`default_nettype none

module tb_flash_apb_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        apb_sel;
    logic        apb_enable;
    logic        apb_write;
    logic [7:0]  apb_addr;
    logic [31:0] apb_wdata;
    logic [31:0] apb_rdata;
    logic        apb_ready;
    logic        apb_slverr;

    int n_checks = 0;
    int n_err    = 0;

    flash_apb_master #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .apb_sel    (apb_sel),
        .apb_enable (apb_enable),
        .apb_write  (apb_write),
        .apb_addr   (apb_addr),
        .apb_wdata  (apb_wdata),
        .apb_rdata  (apb_rdata),
        .apb_ready  (apb_ready),
        .apb_slverr (apb_slverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All APB and response outputs idle/zero.
    task automatic check_quiet(input string tag);
        check({tag, ".rsp_valid"},  {31'd0, rsp_valid},  32'd0);
        check({tag, ".rsp_rdata"},  rsp_rdata,           32'd0);
        check({tag, ".rsp_err"},    {31'd0, rsp_err},    32'd0);
        check({tag, ".apb_sel"},    {31'd0, apb_sel},    32'd0);
        check({tag, ".apb_enable"}, {31'd0, apb_enable}, 32'd0);
        check({tag, ".apb_write"},  {31'd0, apb_write},  32'd0);
        check({tag, ".apb_addr"},   {24'd0, apb_addr},   32'd0);
        check({tag, ".apb_wdata"},  apb_wdata,           32'd0);
    endtask

    task automatic check_apb(input string tag, input logic sel, input logic en,
                             input logic wr, input logic [7:0] addr, input logic [31:0] wd);
        check({tag, ".apb_sel"},    {31'd0, apb_sel},    {31'd0, sel});
        check({tag, ".apb_enable"}, {31'd0, apb_enable}, {31'd0, en});
        check({tag, ".apb_write"},  {31'd0, apb_write},  {31'd0, wr});
        check({tag, ".apb_addr"},   {24'd0, apb_addr},   {24'd0, addr});
        check({tag, ".apb_wdata"},  apb_wdata,           wd);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 8'h00;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        apb_rdata  = 32'h0;
        apb_ready  = 1'b0;
        apb_slverr = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst.req_ready", {31'd0, req_ready}, 32'd0);
        check_quiet("rst");
        reset = 1'b0;
        #1;
        check("rst_rel.req_ready", {31'd0, req_ready}, 32'd1);

        // Write 0x10 <- 0xDEADBEEF, zero-wait responder
        apb_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        check("wr.setup.req_ready", {31'd0, req_ready}, 32'd0);
        check("wr.setup.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_apb("wr.setup", 1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
        tick();
        check("wr.access.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_apb("wr.access", 1'b1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        tick();
        apb_ready = 1'b0;
        check("wr.resp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr.resp.rsp_err",   {31'd0, rsp_err},   32'd0);
        check("wr.resp.rsp_rdata", rsp_rdata,          32'd0);
        check("wr.resp.apb_sel",   {31'd0, apb_sel},   32'd0);
        check("wr.resp.apb_en",    {31'd0, apb_enable}, 32'd0);
        // Next request presented while the response completes: must wait for IDLE
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h10;
        req_wdata = 32'h5555AAAA;
        check("wr.resp.req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        rsp_ready = 1'b0;
        check("b2b.idle.req_ready", {31'd0, req_ready}, 32'd1);
        check("b2b.idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("b2b.idle.apb_sel",   {31'd0, apb_sel},   32'd0);

        // Read 0x10 with 4 wait states, data 0xDEADBEEF
        tick();
        req_valid = 1'b0;
        check_apb("rd.setup", 1'b1, 1'b0, 1'b0, 8'h10, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_apb($sformatf("rd.wait%0d", i), 1'b1, 1'b1, 1'b0, 8'h10, 32'd0);
            check($sformatf("rd.wait%0d.rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        check_apb("rd.ready", 1'b1, 1'b1, 1'b0, 8'h10, 32'd0);
        apb_ready = 1'b1;
        apb_rdata = 32'hDEADBEEF;
        tick();
        apb_ready = 1'b0;
        apb_rdata = 32'h0;
        check("rd.resp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd.resp.rsp_rdata", rsp_rdata,          32'hDEADBEEF);
        check("rd.resp.rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rd.resp.apb_sel",   {31'd0, apb_sel},   32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd.done.rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Read 0x20 terminated with slave error, response held 5 cycles
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h20;
        tick();
        req_valid = 1'b0;
        tick();
        apb_ready  = 1'b1;
        apb_slverr = 1'b1;
        apb_rdata  = 32'h12345678;
        tick();
        apb_ready  = 1'b0;
        apb_slverr = 1'b0;
        apb_rdata  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("err.hold%0d.rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("err.hold%0d.rsp_err", i),   {31'd0, rsp_err},   32'd1);
            check($sformatf("err.hold%0d.rsp_rdata", i), rsp_rdata,          32'd0);
            check($sformatf("err.hold%0d.req_ready", i), {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("err.done.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("err.done.rsp_err",   {31'd0, rsp_err},   32'd0);

        // Reset asserted in ACCESS of a write
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h33;
        req_wdata = 32'hA5A5A5A5;
        tick();
        req_valid = 1'b0;
        tick();
        check_apb("rstacc.access", 1'b1, 1'b1, 1'b1, 8'h33, 32'hA5A5A5A5);
        reset = 1'b1;
        tick();
        check("rstacc.req_ready", {31'd0, req_ready}, 32'd0);
        check_quiet("rstacc");
        reset = 1'b0;
        #1;
        check("rstacc.rel.req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstacc.post%0d.rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
            check($sformatf("rstacc.post%0d.apb_sel", i),   {31'd0, apb_sel},   32'd0);
        end

        // Responder never ready
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h44;
        tick();
        req_valid = 1'b0;
        tick();
`ifdef FLASH_APB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to.acc%0d.apb_enable", i), {31'd0, apb_enable}, 32'd1);
            check($sformatf("to.acc%0d.rsp_valid", i),  {31'd0, rsp_valid},  32'd0);
            tick();
        end
        check("to.resp.rsp_valid",  {31'd0, rsp_valid},  32'd1);
        check("to.resp.rsp_err",    {31'd0, rsp_err},    32'd1);
        check("to.resp.rsp_rdata",  rsp_rdata,           32'd0);
        check("to.resp.apb_sel",    {31'd0, apb_sel},    32'd0);
        check("to.resp.apb_enable", {31'd0, apb_enable}, 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        check("nto.wait.apb_sel",    {31'd0, apb_sel},    32'd1);
        check("nto.wait.apb_enable", {31'd0, apb_enable}, 32'd1);
        check("nto.wait.rsp_valid",  {31'd0, rsp_valid},  32'd0);
        apb_ready = 1'b1;
        apb_rdata = 32'h0BADF00D;
        tick();
        apb_ready = 1'b0;
        apb_rdata = 32'h0;
        check("nto.resp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("nto.resp.rsp_err",   {31'd0, rsp_err},   32'd0);
        check("nto.resp.rsp_rdata", rsp_rdata,          32'h0BADF00D);
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("end.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("end.req_ready", {31'd0, req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
